// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: decodes ALUOp/opcode into a registered control code
// and paces multi-cycle MUL/UDIV. UDIV support is enabled by ALU_DIV_SEQ_EN.
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] inst31_21,
  input  logic [1:0]  ALUOp,
  output logic [3:0]  control_line,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_UDIV = 11'b10011010110;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);
`ifdef ALU_DIV_SEQ_EN
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 2);
`endif

  localparam bit CFG_OK = (MUL_CYCLES >= 2) && (MUL_CYCLES <= 15) &&
                          (DIV_CYCLES >= 2) && (DIV_CYCLES <= 15);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [3:0]  ctrl_nx;
  logic        ill_nx;
  logic        accept;
  logic [3:0]  dec_code;
  logic        dec_ill;
  logic        dec_multi;
  logic [3:0]  dec_cnt;

  always_comb begin
    dec_code  = 4'b0010;
    dec_ill   = 1'b0;
    dec_multi = 1'b0;
    dec_cnt   = 4'd0;
    unique case (ALUOp)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0111;
      2'b11: begin
        dec_code = 4'b1111;
        dec_ill  = 1'b1;
      end
      2'b10: begin
        case (inst31_21)
          OP_SUB: dec_code = 4'b0110;
          OP_AND: dec_code = 4'b0000;
          OP_ORR: dec_code = 4'b0001;
          OP_EOR: dec_code = 4'b0011;
          OP_LSL: dec_code = 4'b0100;
          OP_LSR: dec_code = 4'b0101;
          OP_MUL: begin
            dec_code  = 4'b1000;
            dec_multi = 1'b1;
            dec_cnt   = MUL_LOAD;
          end
`ifdef ALU_DIV_SEQ_EN
          OP_UDIV: begin
            dec_code  = 4'b1001;
            dec_multi = 1'b1;
            dec_cnt   = DIV_LOAD;
          end
`else
          OP_UDIV: begin
            dec_code = 4'b1111;
            dec_ill  = 1'b1;
          end
`endif
          default: dec_code = 4'b0010;
        endcase
      end
      default: dec_code = 4'b0010;
    endcase
  end

  // Reset blocks acceptance so nothing is loaded on the reset edge
  assign in_ready = !reset &&
                    ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == EXEC);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ctrl_nx  = control_line;
    ill_nx   = illegal;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          ctrl_nx  = dec_code;
          ill_nx   = dec_ill;
          cnt_nx   = dec_cnt;
          state_nx = dec_multi ? EXEC : HOLD;
        end else if ((state == HOLD) && out_ready) begin
          state_nx = IDLE;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      control_line <= 4'b0000;
      illegal      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      control_line <= ctrl_nx;
      illegal      <= ill_nx;
    end
  end

  always_ff @(posedge clk) begin : cfg_chk
    assert (CFG_OK)
      else $error("alu_op_sequencer: MUL_CYCLES/DIV_CYCLES out of 2..15");
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: queued expectations from a
// reference decoder, directed latency/hold/reset checks, random stalls.
module tb_alu_op_sequencer;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;

  localparam logic [10:0] SUB_I  = 11'b11001011000;
  localparam logic [10:0] AND_I  = 11'b10001010000;
  localparam logic [10:0] ORR_I  = 11'b10101010000;
  localparam logic [10:0] EOR_I  = 11'b11001010000;
  localparam logic [10:0] LSL_I  = 11'b11010011011;
  localparam logic [10:0] LSR_I  = 11'b11010011010;
  localparam logic [10:0] MUL_I  = 11'b10011011000;
  localparam logic [10:0] UDIV_I = 11'b10011010110;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] inst31_21;
  logic [1:0]  ALUOp;
  logic [3:0]  control_line;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;

  typedef struct packed {
    logic [3:0]  code;
    logic        ill;
    logic [7:0]  lat;
    logic [15:0] acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   vstart = 0;
  bit   prev_v = 0;
  bit   prev_t = 0;
  bit   rnd_on = 0;

  alu_op_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inst31_21(inst31_21),
    .ALUOp(ALUOp),
    .control_line(control_line),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [10:0] ins, input int acc);
    exp_t e;
    e.code = 4'b0010;
    e.ill  = 1'b0;
    e.lat  = 8'd1;
    e.acc  = 16'(acc);
    case (op)
      2'b01: e.code = 4'b0111;
      2'b11: begin e.code = 4'b1111; e.ill = 1'b1; end
      2'b10: begin
        case (ins)
          SUB_I: e.code = 4'b0110;
          AND_I: e.code = 4'b0000;
          ORR_I: e.code = 4'b0001;
          EOR_I: e.code = 4'b0011;
          LSL_I: e.code = 4'b0100;
          LSR_I: e.code = 4'b0101;
          MUL_I: begin e.code = 4'b1000; e.lat = 8'(MUL_CYCLES); end
`ifdef ALU_DIV_SEQ_EN
          UDIV_I: begin e.code = 4'b1001; e.lat = 8'(DIV_CYCLES); end
`else
          UDIV_I: begin e.code = 4'b1111; e.ill = 1'b1; end
`endif
          default: e.code = 4'b0010;
        endcase
      end
      default: e.code = 4'b0010;
    endcase
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on consumption
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      prev_v = 0;
      prev_t = 0;
    end else begin
      if (in_valid && in_ready) q.push_back(model(ALUOp, inst31_21, cyc));
      if (out_valid && (!prev_v || prev_t)) vstart = cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_code", 32'(control_line), 32'(e.code));
          check("sb_illegal", 32'(illegal), 32'(e.ill));
          check("sb_latency", 32'(vstart - int'(e.acc)), 32'(e.lat));
        end
      end
      prev_v = out_valid;
      prev_t = out_valid && out_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [1:0] op, input logic [10:0] ins);
    int n = 0;
    in_valid  = 1'b1;
    ALUOp     = op;
    inst31_21 = ins;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ALUOp     = 2'($urandom);
    inst31_21 = 11'($urandom);
  endtask

  initial begin
    logic [10:0] tbl [10];
    logic [10:0] long_i;
    int   n;
    bit   seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUOp     = 2'b00;
    inst31_21 = 11'd0;
    tbl = '{SUB_I, AND_I, ORR_I, EOR_I, LSL_I, LSR_I, MUL_I, UDIV_I,
            11'h000, 11'h7ff};

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ctrl", 32'(control_line), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_illegal", 32'(illegal), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(2'b10, SUB_I);
    @(negedge clk);
    check("sub_code", 32'(control_line), 32'h6);
    check("sub_valid", 32'(out_valid), 1);
    check("sub_illegal", 32'(illegal), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sub_idle_valid", 32'(out_valid), 0);
    check("sub_idle_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    send(2'b10, MUL_I);
    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
      @(negedge clk);
      check("mul_busy", 32'(busy), 1);
      check("mul_code", 32'(control_line), 32'h8);
      check("mul_not_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mul_valid", 32'(out_valid), 1);
    check("mul_done_busy", 32'(busy), 0);
    check("mul_done_code", 32'(control_line), 32'h8);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(2'b10, AND_I);
    in_valid  = 1'b1;
    ALUOp     = 2'b10;
    inst31_21 = ORR_I;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_code", 32'(control_line), 32'h0);
      check("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("orr_code", 32'(control_line), 32'h1);
    check("orr_valid", 32'(out_valid), 1);
    @(posedge clk); #1;

`ifdef ALU_DIV_SEQ_EN
    long_i = UDIV_I;
`else
    long_i = MUL_I;
`endif
    send(2'b10, long_i);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_busy_pre", 32'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_ctrl", 32'(control_line), 0);
    check("abort_idle", 32'(in_ready), 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_result", 32'(seen), 0);
    @(posedge clk); #1;

    send(2'b11, 11'($urandom));
    @(negedge clk);
    check("op11_code", 32'(control_line), 32'hf);
    check("op11_illegal", 32'(illegal), 1);
    @(posedge clk); #1;
    send(2'b01, 11'($urandom));
    @(negedge clk);
    check("op01_code", 32'(control_line), 32'h7);
    check("op01_illegal", 32'(illegal), 0);
    @(posedge clk); #1;

    send(2'b10, UDIV_I);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
`ifdef ALU_DIV_SEQ_EN
    check("udiv_latency", 32'(n), 32'(DIV_CYCLES));
    check("udiv_code", 32'(control_line), 32'h9);
    check("udiv_illegal", 32'(illegal), 0);
`else
    check("udiv_latency", 32'(n), 1);
    check("udiv_code", 32'(control_line), 32'hf);
    check("udiv_illegal", 32'(illegal), 1);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) send(2'b10, tbl[i]);
    send(2'b00, 11'($urandom));

    rnd_on = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        send(2'($urandom), 11'($urandom));
      else
        send(2'b10, tbl[$urandom_range(0, 9)]);
    end
    rnd_on    = 0;
    out_ready = 1'b1;

    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, cycles from MUL acceptance to out_valid (legal range 2..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 8, cycles from UDIV acceptance to out_valid (legal range 2..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port inst31_21  input  11  instruction opcode field.
REQ-008 SHALL have port ALUOp  input  2  main-control ALU class.
REQ-009 SHALL have port control_line  output  4  registered ALU control code.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port out_valid  output  1  control_line final and result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-013 SHALL have port illegal  output  1  accepted request did not decode; qualified by out_valid.

Function
REQ-014 SHALL decode on acceptance: ALUOp 00 -> 0010; 01 -> 0111; 11 -> 1111 with illegal=1.
REQ-015 SHALL decode ALUOp 10 by inst31_21: 11001011000 SUB 0110; 10001010000 AND 0000; 10101010000 ORR 0001; 11001010000 EOR 0011; 11010011011 LSL 0100; 11010011010 LSR 0101; 10011011000 MUL 1000; 10011010110 UDIV 1001; any other 0010 (ADD/ADDI/branch default).
REQ-016 SHALL implement states IDLE, EXEC, HOLD; in_ready = (state==IDLE) || (state==HOLD && out_ready).
REQ-017 SHALL on acceptance load control_line and illegal; MUL/UDIV go to EXEC with counter = latency-2; all other codes go to HOLD.
REQ-018 SHALL in EXEC hold busy=1, keep control_line stable, decrement counter each cycle, move to HOLD on the cycle counter==0.
REQ-019 SHALL assert out_valid only in HOLD; single-cycle ops give out_valid exactly 1 cycle after acceptance, MUL exactly MUL_CYCLES, UDIV exactly DIV_CYCLES.
REQ-020 SHALL in HOLD with out_ready=0 keep out_valid, control_line, illegal unchanged indefinitely.
REQ-021 SHALL in HOLD with out_ready=1: new accepted request proceeds per REQ-017 (back-to-back, no bubble); else go to IDLE.
REQ-022 SHALL in IDLE keep control_line at last value, out_valid=0, busy=0.
REQ-023 SHALL ignore inst31_21/ALUOp changes except on the acceptance cycle.
REQ-024 SHALL size the counter as 4 bits; parameter values outside legal ranges are a configuration error (assert in simulation).

Reset
REQ-025 SHALL on reset=1 at a clock edge force state IDLE, control_line 0000, counter 0, busy 0, out_valid 0, illegal 0.
REQ-026 SHALL let reset override acceptance and abort EXEC/HOLD without producing out_valid for the aborted operation.
REQ-027 SHALL drive in_ready=0 during the reset-asserted cycle.

Configuration
REQ-028 SHALL compile UDIV support only when macro ALU_DIV_SEQ_EN is defined.
REQ-029 SHALL with ALU_DIV_SEQ_EN defined decode UDIV per REQ-015/REQ-019.
REQ-030 SHALL without ALU_DIV_SEQ_EN decode 10011010110 under ALUOp 10 as 1111, illegal=1, single-cycle (HOLD next cycle); DIV_CYCLES unused.

Verification
REQ-031 SHALL test: reset, then ALUOp=10, inst=11001011000, in_valid 1 cycle, out_ready=1 -> next cycle control_line=0110, out_valid=1, illegal=0, then IDLE.
REQ-032 SHALL test: MUL (10011011000) accepted at cycle T, MUL_CYCLES=4 -> busy=1 cycles T+1..T+3, out_valid=1 at T+4, control_line=1000 throughout.
REQ-033 SHALL test: out_ready=0 for 5 cycles after AND result -> out_valid and 0000 held 5 cycles, in_ready=0; then out_ready=1 with ORR pending -> ORR accepted same cycle, 0001 valid next cycle.
REQ-034 SHALL test: reset asserted at T+2 of UDIV -> next cycle IDLE, busy=0, out_valid=0, control_line=0000, no result ever emitted.
REQ-035 SHALL test: ALUOp=11 -> control_line=1111, illegal=1; ALUOp=01 any inst -> 0111, illegal=0.
REQ-036 SHALL test: UDIV with ALU_DIV_SEQ_EN defined -> out_valid after DIV_CYCLES=8, code 1001; undefined -> out_valid after 1 cycle, code 1111, illegal=1.
